noise_acq_accum: RTL

//  Downstream consumer of the noise-acquisition timing chain: samples ADC[11:0] on each rising edge of Acq_clk

---
 rtl/nmr_acq_pkg.sv | 15 +
 rtl/noise_fifo.sv | 55 +++++
 rtl/noise_acq_accum.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/nmr_acq_pkg.sv
// Shared definitions for the noise-acquisition accumulator: default widths and FSM encoding.
package nmr_acq_pkg;

    localparam int unsigned ADC_W = 12;
    localparam int unsigned ACC_W = 19;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StAcq,
        StPush,
        StDone
    } acq_state_e;

endpackage

// File: rtl/noise_fifo.sv
// Point FIFO: synchronous, first-word-fall-through, with full/empty flags.
// A write while full is accepted only if a read happens in the same cycle.
// A read while empty is ignored and rd_data keeps the last word read.
module noise_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] last_word;
    logic             wr_ok;
    logic             rd_ok;

    // Flags and handshake qualification; extra pointer MSB distinguishes full from empty.
    always_comb begin
        empty   = (wptr == rptr);
        full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        wr_ok   = wr_en && (!full || rd_en);
        rd_ok   = rd_en && !empty;
        rd_data = empty ? last_word : mem[rptr[AW-1:0]];
    end

    // Storage, pointers and the held copy of the last word read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr      <= '0;
            rptr      <= '0;
            last_word <= '0;
        end else begin
            if (wr_ok) begin
                mem[wptr[AW-1:0]] <= wr_data;
                wptr              <= wptr + 1'b1;
            end
            if (rd_ok) begin
                last_word <= mem[rptr[AW-1:0]];
                rptr      <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/noise_acq_accum.sv
// Noise acquisition accumulator: samples the ADC on each Acq_clk rising edge while the noise
// window is open, averages 2^avg_shift samples per point and queues points for the DSP.
// Build option: define NOISE_ACC_RAW_EN to store the raw sum (saturated to 16 bits)
// instead of the truncated mean.
module noise_acq_accum
    import nmr_acq_pkg::*;
#(
    parameter int unsigned ADC_W      = nmr_acq_pkg::ADC_W,
    parameter int unsigned ACC_W      = nmr_acq_pkg::ACC_W,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PTS_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr_int,
    input  logic             acq_en,
    input  logic             acq_clk,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [2:0]       avg_shift,
    input  logic [PTS_W-1:0] num_pts,
    input  logic             rd_en,
    output logic [15:0]      rd_data,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             busy,
    output logic             overflow,
    output logic             interupt
);

    acq_state_e       state;
    logic [2:0]       acq_sync;
    logic             samp_tick;
    logic             samp_vld;
    logic [ADC_W-1:0] adc_q;
    logic [2:0]       shift_q;
    logic [PTS_W-1:0] npts_q;
    logic [PTS_W-1:0] pts_cnt;
    logic [PTS_W-1:0] pts_next;
    logic [7:0]       smp_cnt;
    logic [7:0]       smp_next;
    logic [7:0]       smp_target;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_add;
    logic             fifo_wr;
    logic [15:0]      fifo_wdata;

    // Acq_clk crosses into clk through two flops; third flop gives the rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acq_sync <= '0;
        else        acq_sync <= {acq_sync[1:0], acq_clk};
    end

    assign samp_tick = acq_sync[1] & ~acq_sync[2];

    // Capture the ADC word on the detected edge; samp_vld marks it ready to accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_q    <= '0;
            samp_vld <= 1'b0;
        end else begin
            samp_vld <= samp_tick;
            if (samp_tick) adc_q <= adc_data;
        end
    end

    // Counter arithmetic and point-word formatting.
    always_comb begin
        smp_target = 8'd1 << shift_q;
        smp_next   = smp_cnt + 8'd1;
        pts_next   = pts_cnt + 1'b1;
        acc_add    = acc + ACC_W'(adc_q);
        fifo_wr    = (state == StPush);
`ifdef NOISE_ACC_RAW_EN
        fifo_wdata = (|acc[ACC_W-1:16]) ? 16'hFFFF : acc[15:0];
`else
        // The mean of ADC_W-bit samples always fits in the low bits; upper bits are zero.
        fifo_wdata = 16'(acc >> shift_q);
`endif
    end

    // Run-control FSM with accumulator, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            shift_q  <= '0;
            npts_q   <= '0;
            pts_cnt  <= '0;
            smp_cnt  <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            interupt <= 1'b0;
        end else begin
            if (clr_int) overflow <= 1'b0;
            if (fifo_wr && fifo_full && !rd_en) overflow <= 1'b1;

            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        shift_q <= avg_shift;
                        npts_q  <= num_pts;
                        pts_cnt <= '0;
                        smp_cnt <= '0;
                        acc     <= '0;
                        if (num_pts == '0) begin
                            state    <= StDone;
                            busy     <= 1'b0;
                            interupt <= 1'b1;
                        end else begin
                            state    <= StArm;
                            busy     <= 1'b1;
                            interupt <= 1'b0;
                        end
                    end else if (state == StDone && clr_int) begin
                        state    <= StIdle;
                        interupt <= 1'b0;
                    end
                end
                StArm: begin
                    acc     <= '0;
                    smp_cnt <= '0;
                    if (acq_en) state <= StAcq;
                end
                StAcq: begin
                    if (!acq_en) begin
                        // Window closed mid-point: discard the partial sum.
                        state <= StArm;
                    end else if (samp_vld) begin
                        acc     <= acc_add;
                        smp_cnt <= smp_next;
                        if (smp_next == smp_target) state <= StPush;
                    end
                end
                StPush: begin
                    pts_cnt <= pts_next;
                    if (pts_next == npts_q) begin
                        state    <= StDone;
                        busy     <= 1'b0;
                        interupt <= 1'b1;
                    end else if (samp_vld) begin
                        // Sample landing during the push starts the next point.
                        acc     <= ACC_W'(adc_q);
                        smp_cnt <= 8'd1;
                        state   <= (shift_q == 3'd0) ? StPush : StAcq;
                    end else begin
                        acc     <= '0;
                        smp_cnt <= '0;
                        state   <= StAcq;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    noise_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule
